// File: rtl/cmp_pkg.sv
// Shared types for the sequential comparison unit: FSM states,
// the result flag bundle and a counter-width helper.
package cmp_pkg;

    // Controller states: wait for a request, step through slices, report.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Exactly one of these is set after a completed comparison.
    typedef struct packed {
        logic equal;
        logic less_than;
        logic greater_than;
    } cmp_result_t;

    // Slice counter width; a single-slice build still needs one bit.
    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/slice_comparator.sv
// Combinational unsigned compare of one SLICE-bit operand slice.
module slice_comparator #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    // Plain magnitude compare; signedness is handled upstream by biasing.
    always_comb begin
        lt = (a < b);
        gt = (a > b);
        eq = (a == b);
    end

endmodule

// File: rtl/seq_comparison_unit.sv
// Multi-cycle magnitude comparator. Operands are walked one slice per
// cycle from the most significant slice down, so a narrow comparator
// serves wide operands. Signed compares are turned into unsigned ones by
// flipping the sign bit of both operands at capture time.
module seq_comparison_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SLICE      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             equal,
    output logic             less_than,
    output logic             greater_than
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0] K_INIT = CNT_W'(NSLICE - 1);

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [CNT_W-1:0]  k;
    cmp_result_t       res;
    logic              decided;
    logic              done_r;

    logic              load;
    logic              set_diff;
    logic              set_equal;
    logic              dec_k;

    logic [SLICE-1:0]  slice_a;
    logic [SLICE-1:0]  slice_b;
    logic              s_lt;
    logic              s_gt;
    logic              s_eq;

    // Offset-binary conversion: inverting the sign bit maps two's
    // complement ordering onto unsigned ordering.
    function automatic logic [WIDTH-1:0] bias(input logic [WIDTH-1:0] v,
                                              input logic             sgn);
        logic [WIDTH-1:0] r;
        r            = v;
        r[WIDTH-1]   = v[WIDTH-1] ^ sgn;
        return r;
    endfunction

    assign slice_a = op_a[k*SLICE +: SLICE];
    assign slice_b = op_b[k*SLICE +: SLICE];

    slice_comparator #(
        .SLICE(SLICE)
    ) u_slice_cmp (
        .a (slice_a),
        .b (slice_b),
        .lt(s_lt),
        .gt(s_gt),
        .eq(s_eq)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        set_diff   = 1'b0;
        set_equal  = 1'b0;
        dec_k      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!decided && !s_eq) begin
                    // First differing slice decides the outcome.
                    set_diff = 1'b1;
                    if (EARLY_EXIT != 0 || k == '0) begin
                        state_next = DONE;
                    end else begin
                        dec_k = 1'b1;
                    end
                end else if (k == '0) begin
                    set_equal  = !decided;
                    state_next = DONE;
                end else begin
                    dec_k = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result flags, decision marker, slice counter and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res     <= '0;
            decided <= 1'b0;
            k       <= K_INIT;
            done_r  <= 1'b0;
        end else begin
            done_r <= (state == RUN) && (state_next == DONE);
            if (load) begin
                res     <= '0;
                decided <= 1'b0;
                k       <= K_INIT;
            end else begin
                if (set_diff) begin
                    res.less_than    <= s_lt;
                    res.greater_than <= s_gt;
                    decided          <= 1'b1;
                end
                if (set_equal) begin
                    res.equal <= 1'b1;
                end
                if (dec_k) begin
                    k <= k - 1'b1;
                end
            end
        end
    end

    // Operand capture; contents only matter after a load, so no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            op_a <= bias(a, is_signed);
            op_b <= bias(b, is_signed);
        end
    end

    assign ready        = (state == IDLE);
    assign done         = done_r;
    assign equal        = res.equal;
    assign less_than    = res.less_than;
    assign greater_than = res.greater_than;

endmodule
